// File: rtl/dup_tx_fifo_pkg.sv
// Shared types and TXDBUF readback packing for the DUP transmit FIFO.
package dup_tx_fifo_pkg;
`include "duptxdbuf.vh"

  typedef struct packed {
    logic       abrt;
    logic       eom;
    logic       som;
    logic [7:0] data;
  } hold_t;

  function automatic logic [15:0] txdbuf_rd(hold_t h, logic rxcrc, logic txcrc, logic mntt);
    logic [15:0] r;
    r = '0;
    r[`TXDBUF_TXDAT_LSB +: 8] = h.data;
    r[`TXDBUF_TXSOM]  = h.som;
    r[`TXDBUF_TXEOM]  = h.eom;
    r[`TXDBUF_TXABRT] = h.abrt;
    r[`TXDBUF_MNTT]   = mntt;
    r[`TXDBUF_TXCRC]  = txcrc;
    r[`TXDBUF_RXCRC]  = rxcrc;
    return r;
  endfunction
endpackage

// File: rtl/dup_tx_fifo_if.sv
// Transmit-side handshake between the FIFO (master) and the serializer (slave).
interface dup_tx_fifo_if #(parameter int DWIDTH = 8);
  logic              txVALID;
  logic              txREADY;
  logic [DWIDTH-1:0] txDATA;
  logic              txSOM;
  logic              txEOM;
  logic              txACTIVE;
  logic              txABORT;

  modport master (output txVALID, txDATA, txSOM, txEOM, txABORT, input txREADY, txACTIVE);
  modport slave  (input txVALID, txDATA, txSOM, txEOM, txABORT, output txREADY, txACTIVE);
endinterface

// File: rtl/dup_tx_ram.sv
// FIFO storage: synchronous write, asynchronous read, no reset.
module dup_tx_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/duptxdbuf.vh
// TXDBUF register bit positions and FIFO entry field offsets shared by the
// transmit FIFO control logic and its package.
`ifndef DUPTXDBUF_VH
`define DUPTXDBUF_VH
`define TXDBUF_TXDAT_LSB 0
`define TXDBUF_TXSOM     8
`define TXDBUF_TXEOM     9
`define TXDBUF_TXABRT    10
`define TXDBUF_MNTT      11
`define TXDBUF_TXCRC     12
`define TXDBUF_RXCRC     14
`define TXDBUF_CLR       15
// entry layout {EOM,SOM,DATA}; offsets are added to DWIDTH
`define ENT_SOM_OFS      0
`define ENT_EOM_OFS      1
`endif

// File: rtl/dup_tx_fifo.sv
// DUP transmit character FIFO with TXDBUF holding register and abort/flush.
// Optional underrun detection is compiled in with DUP_TX_UNDERRUN_EN.
`include "duptxdbuf.vh"
module dup_tx_fifo
  import dup_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dupINIT,
  input  logic                   txdbufWRITE,
  input  logic                   devLOBYTE,
  input  logic                   devHIBYTE,
  input  logic [35:0]            dupDATAI,
  input  logic                   dupRXCRC,
  input  logic                   dupTXCRC,
  input  logic                   dupMNTT,
  dup_tx_fifo_if.master          tx,
  output logic                   dupTXDONE,
  output logic                   dupTXOVF,
  output logic                   dupTXUNDR,
  output logic [$clog2(DEPTH):0] txCOUNT,
  output logic [15:0]            regTXDBUF
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DWIDTH + 2;

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [EW-1:0] wdata, rdata;
  hold_t         hold;
  logic          abort_q;

  logic clr_init, wr_lo, wr_hi, abort, clr, full, empty, push, pop;
  assign clr_init = rst | dupINIT;
  assign wr_lo    = txdbufWRITE & devLOBYTE;
  assign wr_hi    = txdbufWRITE & devHIBYTE;
  assign abort    = wr_hi & dupDATAI[`TXDBUF_TXABRT];
  assign clr      = wr_hi & dupDATAI[`TXDBUF_CLR];
  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  // a full FIFO drops the write even if the head leaves this cycle
  assign push     = wr_lo & ~full & ~abort;
  assign pop      = ~empty & tx.txREADY & ~abort;

  assign wdata[DWIDTH-1:0]              = dupDATAI[DWIDTH-1:0];
  assign wdata[DWIDTH + `ENT_SOM_OFS]   = wr_hi & dupDATAI[`TXDBUF_TXSOM];
  assign wdata[DWIDTH + `ENT_EOM_OFS]   = wr_hi & dupDATAI[`TXDBUF_TXEOM];

  dup_tx_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (clr_init) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      hold     <= '0;
      dupTXOVF <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      abort_q <= abort;
      if (abort) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (wr_lo) hold.data <= 8'(dupDATAI[DWIDTH-1:0]);
      if (wr_hi) begin
        hold.som  <= dupDATAI[`TXDBUF_TXSOM];
        hold.eom  <= dupDATAI[`TXDBUF_TXEOM];
        hold.abrt <= dupDATAI[`TXDBUF_TXABRT];
      end
      if (clr) dupTXOVF <= 1'b0;
      if (wr_lo & full & ~abort) dupTXOVF <= 1'b1;
    end
  end

`ifdef DUP_TX_UNDERRUN_EN
  // last_eom starts at 1 so an idle serializer before any pop is not an underrun
  logic last_eom;
  always_ff @(posedge clk) begin
    if (clr_init) begin
      dupTXUNDR <= 1'b0;
      last_eom  <= 1'b1;
    end else begin
      if (pop) last_eom <= rdata[DWIDTH + `ENT_EOM_OFS];
      if (clr) dupTXUNDR <= 1'b0;
      if (tx.txACTIVE & tx.txREADY & empty & ~last_eom) dupTXUNDR <= 1'b1;
    end
  end
`else
  logic unused_active;
  assign unused_active = tx.txACTIVE;
  assign dupTXUNDR     = 1'b0;
`endif

  logic unused_bus;
  assign unused_bus = ^dupDATAI;

  assign tx.txVALID = ~empty;
  assign tx.txDATA  = empty ? '0   : rdata[DWIDTH-1:0];
  assign tx.txSOM   = empty ? 1'b0 : rdata[DWIDTH + `ENT_SOM_OFS];
  assign tx.txEOM   = empty ? 1'b0 : rdata[DWIDTH + `ENT_EOM_OFS];
  assign tx.txABORT = abort_q;
  assign dupTXDONE  = ~full;
  assign txCOUNT    = count;
  assign regTXDBUF  = txdbuf_rd(hold, dupRXCRC, dupTXCRC, dupMNTT);
endmodule

// File: tb/tb_dup_tx_fifo.sv
// Self-checking bench for dup_tx_fifo: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_dup_tx_fifo;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, dupINIT, txdbufWRITE, devLOBYTE, devHIBYTE;
  logic [35:0] dupDATAI;
  logic        dupRXCRC, dupTXCRC, dupMNTT;
  logic        dupTXDONE, dupTXOVF, dupTXUNDR;
  logic [2:0]  txCOUNT;
  logic [15:0] regTXDBUF;

  dup_tx_fifo_if #(.DWIDTH(8)) tx();

  dup_tx_fifo #(.DEPTH(DEPTH), .DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .dupINIT(dupINIT), .txdbufWRITE(txdbufWRITE),
    .devLOBYTE(devLOBYTE), .devHIBYTE(devHIBYTE), .dupDATAI(dupDATAI),
    .dupRXCRC(dupRXCRC), .dupTXCRC(dupTXCRC), .dupMNTT(dupMNTT),
    .tx(tx.master), .dupTXDONE(dupTXDONE), .dupTXOVF(dupTXOVF),
    .dupTXUNDR(dupTXUNDR), .txCOUNT(txCOUNT), .regTXDBUF(regTXDBUF)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef DUP_TX_UNDERRUN_EN
  localparam bit UNDR_EN = 1'b1;
`else
  localparam bit UNDR_EN = 1'b0;
`endif

  // reference model: queue of {eom,som,data}
  logic [9:0] mq[$];
  bit         m_ovf, m_undr, m_leom, m_abort;
  bit         h_som, h_eom, h_abrt;
  logic [7:0] h_data;

  task automatic idle();
    rst = 0; dupINIT = 0; txdbufWRITE = 0; devLOBYTE = 0; devHIBYTE = 0;
    dupDATAI = '0; dupRXCRC = 0; dupTXCRC = 0; dupMNTT = 0;
    tx.txREADY = 0; tx.txACTIVE = 0;
  endtask

  task automatic model_edge();
    bit wl, wh, ab, cl, do_push, do_pop;
    wl = txdbufWRITE && devLOBYTE;
    wh = txdbufWRITE && devHIBYTE;
    if (rst || dupINIT) begin
      mq.delete(); m_ovf = 0; m_undr = 0; m_leom = 1; m_abort = 0;
      h_som = 0; h_eom = 0; h_abrt = 0; h_data = 0;
      return;
    end
    ab = wh && dupDATAI[10];
    cl = wh && dupDATAI[15];
    do_pop  = mq.size() > 0 && tx.txREADY && !ab;
    do_push = wl && mq.size() < DEPTH && !ab;
    if (cl) begin m_ovf = 0; m_undr = 0; end
    if (wl && mq.size() == DEPTH && !ab) m_ovf = 1;
    if (UNDR_EN && tx.txACTIVE && tx.txREADY && mq.size() == 0 && !m_leom) m_undr = 1;
    if (do_pop) begin m_leom = mq[0][9]; void'(mq.pop_front()); end
    if (do_push) mq.push_back({wh && dupDATAI[9], wh && dupDATAI[8], dupDATAI[7:0]});
    if (ab) mq.delete();
    m_abort = ab;
    if (wl) h_data = dupDATAI[7:0];
    if (wh) begin h_som = dupDATAI[8]; h_eom = dupDATAI[9]; h_abrt = dupDATAI[10]; end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic push_lo(input logic [7:0] d);
    txdbufWRITE = 1; devLOBYTE = 1; devHIBYTE = 0; dupDATAI = 36'(d);
    step();
    idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    txdbufWRITE = 1; devLOBYTE = 1; devHIBYTE = 1; dupDATAI = 36'h3AA;
    step(); idle();
    checks++;
    if ({tx.txVALID, txCOUNT, dupTXDONE, dupTXOVF, dupTXUNDR, tx.txABORT, regTXDBUF[10:0]} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0}) begin
      errors++;
      $display("FAIL reset: got valid=%b cnt=%0d done=%b ovf=%b undr=%b abt=%b reg=%h want 0,0,1,0,0,0,000",
               tx.txVALID, txCOUNT, dupTXDONE, dupTXOVF, dupTXUNDR, tx.txABORT, regTXDBUF[10:0]);
    end
  endtask

  task automatic test_first_push();
    do_reset();
    txdbufWRITE = 1; devLOBYTE = 1; devHIBYTE = 1; dupDATAI = 36'h141;
    #1;
    checks++;
    if (tx.txVALID !== 1'b0) begin
      errors++; $display("FAIL no_bypass: got valid=%b want 0", tx.txVALID);
    end
    step(); idle();
    checks++;
    if ({tx.txVALID, tx.txDATA, tx.txSOM, tx.txEOM, txCOUNT} !== {1'b1, 8'h41, 1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL first_push: got valid=%b data=%h som=%b eom=%b cnt=%0d want 1,41,1,0,1",
               tx.txVALID, tx.txDATA, tx.txSOM, tx.txEOM, txCOUNT);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) push_lo(8'(8'h10 + i));
    checks++;
    if ({txCOUNT, dupTXDONE, dupTXOVF} !== {3'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL overflow: got cnt=%0d done=%b ovf=%b want 4,0,1", txCOUNT, dupTXDONE, dupTXOVF);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx.txDATA !== 8'(8'h10 + i)) begin
        errors++; $display("FAIL drain[%0d]: got %h want %h", i, tx.txDATA, 8'(8'h10 + i));
      end
      tx.txREADY = 1; step(); idle();
    end
    checks++;
    if ({tx.txVALID, tx.txDATA} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL drain_empty: got valid=%b data=%h want 0,00", tx.txVALID, tx.txDATA);
    end
    txdbufWRITE = 1; devHIBYTE = 1; dupDATAI = 36'h8000;
    step(); idle();
    checks++;
    if (dupTXOVF !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", dupTXOVF);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_lo(8'h80); push_lo(8'h81);
    for (int k = 0; k < 10; k++) begin
      txdbufWRITE = 1; devLOBYTE = 1; dupDATAI = 36'(8'h82 + k); tx.txREADY = 1;
      step(); idle();
      checks++;
      if ({txCOUNT, tx.txDATA} !== {3'd2, 8'(8'h81 + k)}) begin
        errors++;
        $display("FAIL b2b[%0d]: got cnt=%0d head=%h want 2,%h", k, txCOUNT, tx.txDATA, 8'(8'h81 + k));
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    push_lo(8'h01); push_lo(8'h02); push_lo(8'h03);
    txdbufWRITE = 1; devLOBYTE = 1; devHIBYTE = 1; dupDATAI = 36'h477; tx.txREADY = 1;
    step(); idle();
    checks++;
    if ({tx.txABORT, txCOUNT, tx.txVALID} !== {1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort: got abt=%b cnt=%0d valid=%b want 1,0,0", tx.txABORT, txCOUNT, tx.txVALID);
    end
    step();
    checks++;
    if (tx.txABORT !== 1'b0) begin
      errors++; $display("FAIL abort_pulse: got %b want 0", tx.txABORT);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    push_lo(8'h55);
    tx.txREADY = 1; step();
    tx.txACTIVE = 1; step(); idle();
    checks++;
    if (dupTXUNDR !== UNDR_EN) begin
      errors++; $display("FAIL underrun: got %b want %b", dupTXUNDR, UNDR_EN);
    end
    txdbufWRITE = 1; devHIBYTE = 1; dupDATAI = 36'h8000;
    step(); idle();
    checks++;
    if (dupTXUNDR !== 1'b0) begin
      errors++; $display("FAIL undr_clear: got %b want 0", dupTXUNDR);
    end
  endtask

  task automatic test_init();
    do_reset();
    push_lo(8'h11); push_lo(8'h22);
    dupINIT = 1; txdbufWRITE = 1; devLOBYTE = 1; devHIBYTE = 1; dupDATAI = 36'h3AA;
    step(); idle();
    checks++;
    if ({txCOUNT, regTXDBUF[10:0], dupTXDONE} !== {3'd0, 11'd0, 1'b1}) begin
      errors++;
      $display("FAIL init: got cnt=%0d reg=%h done=%b want 0,000,1", txCOUNT, regTXDBUF[10:0], dupTXDONE);
    end
  endtask

  task automatic test_random();
    logic [32:0] got, exp;
    logic [9:0]  hd;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(63) == 0);
      dupINIT     = ($urandom_range(63) == 0);
      txdbufWRITE = $urandom_range(1);
      devLOBYTE   = $urandom_range(1);
      devHIBYTE   = $urandom_range(1);
      dupDATAI    = {$urandom, $urandom};
      dupDATAI[10] = ($urandom_range(11) == 0);
      tx.txREADY  = ($urandom_range(2) == 0);
      tx.txACTIVE = $urandom_range(1);
      dupRXCRC = $urandom_range(1); dupTXCRC = $urandom_range(1); dupMNTT = $urandom_range(1);
      step();
      hd  = (mq.size() > 0) ? mq[0] : 10'd0;
      exp = {mq.size() > 0, hd[7:0], hd[8], hd[9], 3'(mq.size()), mq.size() < DEPTH,
             m_ovf, m_undr, m_abort,
             1'b0, dupRXCRC, 1'b0, dupTXCRC, dupMNTT, h_abrt, h_eom, h_som, h_data};
      got = {tx.txVALID, tx.txDATA, tx.txSOM, tx.txEOM, txCOUNT, dupTXDONE,
             dupTXOVF, dupTXUNDR, tx.txABORT, regTXDBUF};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", n, got, exp);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_first_push();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_underrun();
    test_init();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
